otter_dmem_arbiter: RTL

Round-robin arbiter and sequencer for the data port (port 2) of the OTTER byte-addressable dual-port memory. It shares that port among up to four requesters, such as load/store units or a store buffer in the out-of-order core, over valid/ready handshakes. It tracks the one-cycle read latency, routes each response and its tag back to the requester that issued it, rejects misaligned accesses without touching memory, and squashes in-flight read responses on FLUSH.

---
 rtl/otter_dmem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/otter_dmem_arbiter.sv
// Round-robin arbiter sharing OTTER memory port 2 among N_REQ requesters, with response routing.
// Latency: grant and memory access in cycle N, response (tag, load data, error) in cycle N+1.
// Backpressure: REQ_READY grants at most one requester per cycle; responses cannot be stalled.
module otter_dmem_arbiter #(
    parameter int N_REQ = 2,
    parameter int TAG_W = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   FLUSH,
    input  logic [N_REQ-1:0]       REQ_VALID,
    output logic [N_REQ-1:0]       REQ_READY,
    input  logic [N_REQ-1:0]       REQ_WE,
    input  logic [N_REQ*32-1:0]    REQ_ADDR,
    input  logic [N_REQ*32-1:0]    REQ_WDATA,
    input  logic [N_REQ*2-1:0]     REQ_SIZE,
    input  logic [N_REQ-1:0]       REQ_SIGN,
    input  logic [N_REQ*TAG_W-1:0] REQ_TAG,
    output logic [31:0]            MEM_ADDR2,
    output logic [31:0]            MEM_DIN2,
    output logic                   MEM_WRITE2,
    output logic                   MEM_READ2,
    output logic [1:0]             MEM_SIZE,
    output logic                   MEM_SIGN,
    input  logic [31:0]            MEM_DOUT2,
    output logic [N_REQ-1:0]       RSP_VALID,
    output logic                   RSP_WE,
    output logic                   RSP_ERR,
    output logic [31:0]            RSP_DATA,
    output logic [TAG_W-1:0]       RSP_TAG
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    gnt_id;
    logic             gnt;

    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [1:0]       sel_size;
    logic             sel_sign;
    logic [TAG_W-1:0] sel_tag;
    logic             sel_err;

    logic             rsp_vld;
    logic [PW-1:0]    rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_we;
    logic             rsp_err;
    logic             rsp_show;

    // Grant the first valid requester scanning upward from ptr; reset and flush block all grants.
    always_comb begin
        gnt    = 1'b0;
        gnt_id = '0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PW'((int'(ptr) + k) % N_REQ);
            if (!gnt && REQ_VALID[cand]) begin
                gnt    = 1'b1;
                gnt_id = cand;
            end
        end
        if (RST || FLUSH) begin
            gnt = 1'b0;
        end
    end

    // Mux the granted requester's fields onto a single set of selected signals.
    always_comb begin
        REQ_READY = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_size  = 2'd2;
        sel_sign  = 1'b0;
        sel_tag   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt && gnt_id == PW'(i)) begin
                REQ_READY[i] = 1'b1;
                sel_we       = REQ_WE[i];
                sel_addr     = REQ_ADDR[i*32 +: 32];
                sel_wdata    = REQ_WDATA[i*32 +: 32];
                sel_size     = REQ_SIZE[i*2 +: 2];
                sel_sign     = REQ_SIGN[i];
                sel_tag      = REQ_TAG[i*TAG_W +: TAG_W];
            end
        end
    end

    // Misaligned accesses still take the slot but never strobe the memory.
    always_comb begin
        sel_err = 1'b0;
        case (sel_size)
            2'd0:    sel_err = 1'b0;
            2'd1:    sel_err = sel_addr[0];
            2'd2:    sel_err = (sel_addr[1:0] != 2'b00);
            default: sel_err = 1'b1;
        endcase
        MEM_ADDR2  = sel_addr;
        MEM_DIN2   = sel_wdata;
        MEM_SIZE   = sel_size;
        MEM_SIGN   = sel_sign;
        MEM_READ2  = gnt && !sel_we && !sel_err;
        MEM_WRITE2 = gnt && sel_we && !sel_err;
    end

    // Advance the priority pointer past each winner and capture who gets the next-cycle response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr     <= '0;
            rsp_vld <= 1'b0;
            rsp_id  <= '0;
            rsp_tag <= '0;
            rsp_we  <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            rsp_vld <= gnt;
            if (gnt) begin
                ptr     <= (gnt_id == PW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
                rsp_id  <= gnt_id;
                rsp_tag <= sel_tag;
                rsp_we  <= sel_we;
                rsp_err <= sel_err;
            end
        end
    end

    // Present the captured response; flush squashes it and load data flows straight from memory.
    always_comb begin
        rsp_show  = rsp_vld && !FLUSH && !RST;
        RSP_VALID = '0;
        for (int i = 0; i < N_REQ; i++) begin
            RSP_VALID[i] = rsp_show && (rsp_id == PW'(i));
        end
        RSP_WE   = rsp_show && rsp_we;
        RSP_ERR  = rsp_show && rsp_err;
        RSP_TAG  = rsp_show ? rsp_tag : '0;
        RSP_DATA = (rsp_show && !rsp_we && !rsp_err) ? MEM_DOUT2 : 32'h0;
    end

endmodule
